ghost_fright_ctrl: RTL and testbench
====================================

Name: ghost_fright_ctrl

Overview:
- Tracks the ghost's frightened/eaten lifecycle and detects Pac-Man/ghost collisions.
- Consumes the pellet stage's big_pellet_eaten and win pulses. Feeds ghost_survival_timer and slow_ghost_intercept back to the pellet stage for scoring.
- Drives ghost movement speed, sprite palette (blue/flashing/eyes) and the Pac-Man death request.
- Runs on the system clock and advances time only on the one-cycle per-frame tick.

Parameters:
- FRIGHT_FRAMES, 180, frightened duration in frames (3 s at 60 Hz); must fit in 8 bits.
- FLASH_FRAMES, 60, remaining-frame threshold at and below which the frightened sprite flashes.
- FLASH_HALF, 8, frames per flash half-period.
- RESPAWN_FRAMES, 120, frames an eaten ghost spends as eyes before returning to normal.
- HIT_DIST, 12, pixel distance per axis below which sprites collide.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- frame_tick  in  1  one-cycle pulse per video frame
- pacX  in  10  Pac-Man centre X, pixels
- pacY  in  10  Pac-Man centre Y, pixels
- ghostX  in  10  ghost centre X, pixels
- ghostY  in  10  ghost centre Y, pixels
- big_pellet_eaten  in  1  one-cycle pulse from the pellet stage
- win  in  1  level cleared (level-held)
- ghost_survival_timer  out  8  frightened frames remaining; 0 when not FRIGHT
- frightened  out  1  state==FRIGHT
- ghost_slow  out  1  ghost moves at half speed (FRIGHT)
- ghost_flash  out  1  draw white instead of blue
- ghost_eyes  out  1  state==EATEN; draw eyes only, ghost non-colliding
- slow_ghost_intercept  out  1  one-cycle pulse: frightened ghost eaten
- pacman_caught  out  1  one-cycle pulse: normal ghost hit Pac-Man
- ghost_state  out  2  00 NORMAL, 01 FRIGHT, 10 EATEN, 11 DONE

Behaviour:
- Reset values:
  - State NORMAL.
  - Frightened timer, respawn counter and flash counter are 0.
  - All outputs are 0.
  - Reset mid-operation aborts any state on the next edge.
- All outputs are registered. A qualifying input in cycle N is reflected at the edge ending cycle N (visible in cycle N+1).
- Collision:
  - hit = |pacX-ghostX| < HIT_DIST and |pacY-ghostY| < HIT_DIST.
  - Compute the differences as 11-bit signed values, then take the absolute value. No wrap-around.
  - Evaluated every clock, not only on frame_tick.
- NORMAL:
  - big_pellet_eaten → FRIGHT, timer = FRIGHT_FRAMES, flash counter cleared.
  - Else if hit → pacman_caught pulse, remain NORMAL.
  - big_pellet_eaten takes priority over hit in the same cycle: no caught pulse.
- FRIGHT:
  - big_pellet_eaten → reload timer to FRIGHT_FRAMES (priority over frame_tick decrement).
  - Else if hit → slow_ghost_intercept pulse for exactly 1 cycle, go to EATEN, timer = 0, respawn = RESPAWN_FRAMES.
  - Else on frame_tick: if timer == 1 → timer = 0 and go to NORMAL; otherwise timer decrements.
  - Hit has priority over frame_tick in the same cycle.
  - Timer never underflows.
- EATEN:
  - On frame_tick the respawn counter decrements; reaching 0 → NORMAL.
  - big_pellet_eaten is ignored; the eyes ghost is not re-frightened.
  - hit is ignored: no pulses.
- DONE:
  - Entered from any state when win == 1 (highest priority, above all events).
  - All outputs are forced to 0 except ghost_state = 11.
  - Remains in DONE until reset.
- Flash:
  - Flash counter increments on frame_tick while in FRIGHT and wraps at 2*FLASH_HALF.
  - ghost_flash = FRIGHT and timer <= FLASH_FRAMES and counter >= FLASH_HALF.
  - 0 outside FRIGHT.
- Output decoding:
  - ghost_slow = frightened = (state == FRIGHT).
  - ghost_survival_timer mirrors the internal timer (0 outside FRIGHT).
- At most one of slow_ghost_intercept / pacman_caught is asserted in any cycle. Neither repeats while the overlap persists, because of the state change (EATEN) or the caller's death handling. In NORMAL, however, pacman_caught pulses every cycle hit is held.

Test Plan:
- Reset, then big_pellet_eaten pulse → next cycle frightened=1, timer=180, ghost_state=01. After 180 frame_ticks → timer=0, state=00. No intercept pulse.
- In FRIGHT with timer=100, place ghost at (300,200) and Pac-Man at (305,210) → slow_ghost_intercept high for exactly 1 cycle, ghost_eyes=1, state=10. After 120 frame_ticks → state=00.
- NORMAL with Pac-Man at (300,200) and ghost at (311,200) → pacman_caught=1. Move ghost to (312,200) → no pulse. Same-cycle big pellet plus hit → FRIGHT, no caught pulse.
- FRIGHT at timer=5, then big_pellet_eaten coincident with frame_tick → timer=180 (reload, not 179).
- Timer ≤60 → ghost_flash toggles every 8 frame_ticks. Timer=61 → ghost_flash=0.
- win asserted during FRIGHT, then during EATEN → state=11, all other outputs 0, subsequent big pellet and hit ignored. Reset → state=00.

Source files
------------

// File: rtl/ghost_fright_if.sv
// Bundle of the ghost lifecycle inputs (frame tick, positions, pellet/win events)
// and the resulting speed, palette, scoring and death outputs.
interface ghost_fright_if #(
  parameter int DATA_W = 10
);
  logic              frame_tick;
  logic [DATA_W-1:0] pacX;
  logic [DATA_W-1:0] pacY;
  logic [DATA_W-1:0] ghostX;
  logic [DATA_W-1:0] ghostY;
  logic              big_pellet_eaten;
  logic              win;
  logic [7:0]        ghost_survival_timer;
  logic              frightened;
  logic              ghost_slow;
  logic              ghost_flash;
  logic              ghost_eyes;
  logic              slow_ghost_intercept;
  logic              pacman_caught;
  logic [1:0]        ghost_state;

  modport master (
    output frame_tick, pacX, pacY, ghostX, ghostY, big_pellet_eaten, win,
    input  ghost_survival_timer, frightened, ghost_slow, ghost_flash, ghost_eyes,
           slow_ghost_intercept, pacman_caught, ghost_state
  );

  modport slave (
    input  frame_tick, pacX, pacY, ghostX, ghostY, big_pellet_eaten, win,
    output ghost_survival_timer, frightened, ghost_slow, ghost_flash, ghost_eyes,
           slow_ghost_intercept, pacman_caught, ghost_state
  );
endinterface

// File: rtl/ghost_fright_ctrl.sv
// Ghost frightened/eaten lifecycle FSM with per-clock collision detection.
// All outputs are registered from the next-state values.
module ghost_fright_ctrl #(
  parameter int DATA_W         = 10,
  parameter int FRIGHT_FRAMES  = 180,
  parameter int FLASH_FRAMES   = 60,
  parameter int FLASH_HALF     = 8,
  parameter int RESPAWN_FRAMES = 120,
  parameter int HIT_DIST       = 12
) (
  input logic          clk,
  input logic          reset,
  ghost_fright_if.slave bus
);
  localparam int FC_W      = $clog2(2 * FLASH_HALF) + 1;
  localparam int FLASH_TOP = 2 * FLASH_HALF - 1;

  localparam logic [DATA_W:0] HIT_LIM      = HIT_DIST[DATA_W:0];
  localparam logic [7:0]      FRIGHT_INIT  = FRIGHT_FRAMES[7:0];
  localparam logic [7:0]      FLASH_LIM    = FLASH_FRAMES[7:0];
  localparam logic [7:0]      RESPAWN_INIT = RESPAWN_FRAMES[7:0];
  localparam logic [FC_W-1:0] FLASH_MID    = FLASH_HALF[FC_W-1:0];
  localparam logic [FC_W-1:0] FLASH_WRAP   = FLASH_TOP[FC_W-1:0];

  typedef enum logic [1:0] {
    S_NORMAL = 2'b00,
    S_FRIGHT = 2'b01,
    S_EATEN  = 2'b10,
    S_DONE   = 2'b11
  } state_t;

  // Differences are taken one bit wider than the coordinates so they never wrap.
  function automatic logic [DATA_W:0] abs_diff(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
    logic signed [DATA_W:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? $unsigned(-d) : $unsigned(d);
  endfunction

  state_t          state_p0, state_n;
  logic [7:0]      timer_p0, timer_n;
  logic [7:0]      respawn_p0, respawn_n;
  logic [FC_W-1:0] flash_p0, flash_n;
  logic            intercept_n, caught_n;
  logic            hit;

  logic [7:0]      survival_p0;
  logic            frightened_p0, flash_out_p0, eyes_p0;
  logic            intercept_p0, caught_p0;
  logic [1:0]      ghost_state_p0;

  assign hit = (abs_diff(bus.pacX, bus.ghostX) < HIT_LIM) &&
               (abs_diff(bus.pacY, bus.ghostY) < HIT_LIM);

  always_comb begin
    state_n     = state_p0;
    timer_n     = timer_p0;
    respawn_n   = respawn_p0;
    flash_n     = flash_p0;
    intercept_n = 1'b0;
    caught_n    = 1'b0;
    if (bus.win) begin
      state_n   = S_DONE;
      timer_n   = '0;
      respawn_n = '0;
      flash_n   = '0;
    end else begin
      case (state_p0)
        S_NORMAL: begin
          if (bus.big_pellet_eaten) begin
            state_n = S_FRIGHT;
            timer_n = FRIGHT_INIT;
            flash_n = '0;
          end else if (hit) begin
            caught_n = 1'b1;
          end
        end
        S_FRIGHT: begin
          if (bus.frame_tick)
            flash_n = (flash_p0 == FLASH_WRAP) ? '0 : flash_p0 + 1'b1;
          if (bus.big_pellet_eaten) begin
            timer_n = FRIGHT_INIT;
          end else if (hit) begin
            intercept_n = 1'b1;
            state_n     = S_EATEN;
            timer_n     = '0;
            respawn_n   = RESPAWN_INIT;
          end else if (bus.frame_tick) begin
            if (timer_p0 <= 8'd1) begin
              timer_n = '0;
              state_n = S_NORMAL;
            end else begin
              timer_n = timer_p0 - 8'd1;
            end
          end
        end
        S_EATEN: begin
          if (bus.frame_tick) begin
            if (respawn_p0 <= 8'd1) begin
              respawn_n = '0;
              state_n   = S_NORMAL;
            end else begin
              respawn_n = respawn_p0 - 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Stage p0: state and decoded outputs register together on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_p0       <= S_NORMAL;
      timer_p0       <= '0;
      respawn_p0     <= '0;
      flash_p0       <= '0;
      survival_p0    <= '0;
      frightened_p0  <= 1'b0;
      flash_out_p0   <= 1'b0;
      eyes_p0        <= 1'b0;
      intercept_p0   <= 1'b0;
      caught_p0      <= 1'b0;
      ghost_state_p0 <= 2'b00;
    end else begin
      state_p0       <= state_n;
      timer_p0       <= timer_n;
      respawn_p0     <= respawn_n;
      flash_p0       <= flash_n;
      survival_p0    <= (state_n == S_FRIGHT) ? timer_n : 8'd0;
      frightened_p0  <= (state_n == S_FRIGHT);
      flash_out_p0   <= (state_n == S_FRIGHT) && (timer_n <= FLASH_LIM) &&
                        (flash_n >= FLASH_MID);
      eyes_p0        <= (state_n == S_EATEN);
      intercept_p0   <= intercept_n;
      caught_p0      <= caught_n;
      ghost_state_p0 <= state_n;
    end
  end

  assign bus.ghost_survival_timer = survival_p0;
  assign bus.frightened           = frightened_p0;
  assign bus.ghost_slow           = frightened_p0;
  assign bus.ghost_flash          = flash_out_p0;
  assign bus.ghost_eyes           = eyes_p0;
  assign bus.slow_ghost_intercept = intercept_p0;
  assign bus.pacman_caught        = caught_p0;
  assign bus.ghost_state          = ghost_state_p0;
endmodule

// File: tb/tb_ghost_fright_ctrl.sv
// Directed bench for ghost_fright_ctrl: fright timing, intercept, caught,
// reload priority, flashing and the DONE lock.
module tb_ghost_fright_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  logic seen_int, seen_caught;

  ghost_fright_if #(.DATA_W(10)) gif ();

  ghost_fright_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (gif.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (gif.slow_ghost_intercept === 1'b1) seen_int = 1'b1;
      if (gif.pacman_caught === 1'b1) seen_caught = 1'b1;
    end
  endtask

  task automatic frame(input int n);
    repeat (n) begin
      gif.frame_tick = 1'b1;
      cyc(1);
      gif.frame_tick = 1'b0;
    end
  endtask

  task automatic pellet();
    gif.big_pellet_eaten = 1'b1;
    cyc(1);
    gif.big_pellet_eaten = 1'b0;
  endtask

  task automatic apart();
    gif.pacX = 10'd100; gif.pacY = 10'd100;
    gif.ghostX = 10'd500; gif.ghostY = 10'd400;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
  endtask

  initial begin
    gif.frame_tick = 1'b0;
    gif.big_pellet_eaten = 1'b0;
    gif.win = 1'b0;
    apart();
    seen_int = 1'b0;
    seen_caught = 1'b0;
    do_reset();

    // Reset values
    chk("rst_state", gif.ghost_state, 0);
    chk("rst_timer", gif.ghost_survival_timer, 0);
    chk("rst_fright", gif.frightened, 0);
    chk("rst_flash", gif.ghost_flash, 0);
    chk("rst_eyes", gif.ghost_eyes, 0);
    chk("rst_caught", gif.pacman_caught, 0);

    // Full fright period with no contact
    pellet();
    chk("fr_state", gif.ghost_state, 1);
    chk("fr_fright", gif.frightened, 1);
    chk("fr_slow", gif.ghost_slow, 1);
    chk("fr_timer", gif.ghost_survival_timer, 180);
    frame(179);
    chk("fr_timer1", gif.ghost_survival_timer, 1);
    chk("fr_state1", gif.ghost_state, 1);
    frame(1);
    chk("fr_end_timer", gif.ghost_survival_timer, 0);
    chk("fr_end_state", gif.ghost_state, 0);
    chk("fr_end_fright", gif.frightened, 0);
    chk("fr_no_int", seen_int, 0);

    // Intercept of a frightened ghost at timer 100
    pellet();
    frame(80);
    chk("ic_timer100", gif.ghost_survival_timer, 100);
    gif.ghostX = 10'd300; gif.ghostY = 10'd200;
    gif.pacX = 10'd305; gif.pacY = 10'd210;
    cyc(1);
    chk("ic_pulse", gif.slow_ghost_intercept, 1);
    chk("ic_eyes", gif.ghost_eyes, 1);
    chk("ic_state", gif.ghost_state, 2);
    chk("ic_timer0", gif.ghost_survival_timer, 0);
    chk("ic_fright0", gif.frightened, 0);
    cyc(1);
    chk("ic_pulse_once", gif.slow_ghost_intercept, 0);
    chk("ic_no_caught", gif.pacman_caught, 0);
    apart();
    pellet();
    chk("eat_ignore_pellet", gif.ghost_state, 2);
    frame(119);
    chk("eat_state119", gif.ghost_state, 2);
    frame(1);
    chk("eat_respawn", gif.ghost_state, 0);
    chk("eat_eyes0", gif.ghost_eyes, 0);

    // Normal-state collisions at the distance boundary
    gif.pacX = 10'd300; gif.pacY = 10'd200;
    gif.ghostX = 10'd311; gif.ghostY = 10'd200;
    cyc(1);
    chk("nc_hit11", gif.pacman_caught, 1);
    cyc(1);
    chk("nc_held", gif.pacman_caught, 1);
    gif.ghostX = 10'd312;
    cyc(1);
    chk("nc_miss12", gif.pacman_caught, 0);
    gif.ghostX = 10'd289;
    cyc(1);
    chk("nc_hit_neg11", gif.pacman_caught, 1);
    gif.ghostX = 10'd300; gif.ghostY = 10'd188;
    cyc(1);
    chk("nc_miss_y12", gif.pacman_caught, 0);
    gif.ghostY = 10'd200; gif.ghostX = 10'd311;
    gif.big_pellet_eaten = 1'b1;
    cyc(1);
    gif.big_pellet_eaten = 1'b0;
    apart();
    chk("nc_pel_no_caught", gif.pacman_caught, 0);
    chk("nc_pel_state", gif.ghost_state, 1);
    chk("nc_pel_timer", gif.ghost_survival_timer, 180);

    // Reload beats the frame decrement
    frame(175);
    chk("rl_timer5", gif.ghost_survival_timer, 5);
    gif.big_pellet_eaten = 1'b1;
    gif.frame_tick = 1'b1;
    cyc(1);
    gif.big_pellet_eaten = 1'b0;
    gif.frame_tick = 1'b0;
    chk("rl_timer180", gif.ghost_survival_timer, 180);
    frame(180);
    chk("rl_back_normal", gif.ghost_state, 0);

    // Flash: counter 8 after 8 ticks, reload keeps it, then timer 61
    pellet();
    frame(8);
    chk("fl_high_timer", gif.ghost_flash, 0);
    pellet();
    chk("fl_reload", gif.ghost_survival_timer, 180);
    frame(119);
    chk("fl_t61_timer", gif.ghost_survival_timer, 61);
    chk("fl_t61", gif.ghost_flash, 0);
    frame(1);
    chk("fl_t60", gif.ghost_flash, 0);
    frame(8);
    chk("fl_t52_timer", gif.ghost_survival_timer, 52);
    chk("fl_t52", gif.ghost_flash, 1);
    frame(8);
    chk("fl_t44", gif.ghost_flash, 0);
    frame(8);
    chk("fl_t36", gif.ghost_flash, 1);
    frame(7);
    chk("fl_t29", gif.ghost_flash, 1);
    frame(1);
    chk("fl_t28", gif.ghost_flash, 0);

    // Win during FRIGHT locks into DONE
    frame(4);
    gif.win = 1'b1;
    cyc(1);
    chk("wf_state", gif.ghost_state, 3);
    chk("wf_fright", gif.frightened, 0);
    chk("wf_slow", gif.ghost_slow, 0);
    chk("wf_flash", gif.ghost_flash, 0);
    chk("wf_timer", gif.ghost_survival_timer, 0);
    gif.pacX = 10'd300; gif.pacY = 10'd200;
    gif.ghostX = 10'd302; gif.ghostY = 10'd201;
    seen_int = 1'b0;
    seen_caught = 1'b0;
    pellet();
    cyc(2);
    chk("wf_lock_state", gif.ghost_state, 3);
    chk("wf_no_caught", seen_caught, 0);
    chk("wf_no_int", seen_int, 0);
    chk("wf_lock_fright", gif.frightened, 0);
    gif.win = 1'b0;
    cyc(1);
    chk("wf_stays_done", gif.ghost_state, 3);
    apart();
    do_reset();
    chk("wf_reset", gif.ghost_state, 0);

    // Win during EATEN
    pellet();
    gif.pacX = 10'd300; gif.pacY = 10'd200;
    gif.ghostX = 10'd300; gif.ghostY = 10'd200;
    cyc(1);
    apart();
    chk("we_eaten", gif.ghost_state, 2);
    gif.win = 1'b1;
    cyc(1);
    chk("we_state", gif.ghost_state, 3);
    chk("we_eyes", gif.ghost_eyes, 0);
    chk("we_int", gif.slow_ghost_intercept, 0);
    gif.win = 1'b0;
    do_reset();
    chk("we_reset_state", gif.ghost_state, 0);
    chk("we_reset_timer", gif.ghost_survival_timer, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
